// File: rtl/arith_order_seq.sv
//-----------------------------------------------------------------------------
// arith_order_seq
//
// Initiator side of the arithmetic control handshake. One decoded arithmetic
// instruction is accepted in IDLE and expanded into the full control sequence:
//   clear A -> read operand A into C -> move C to A
//           -> read operand B into C -> move C to B
//           -> order pulse -> wait for answer -> optional C write-back.
// A watchdog covers orders that never answer (add/div overflow abandons the
// order silently). It reports overflow and clears A instead of hanging.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   start_i              accept instruction (sampled in IDLE only)
//   opcode_i[2:0]        0 add, 1 sub, 2 mul, 3 div, 4 and, 5-7 illegal
//   abs_i                operands are taken as absolute values
//   write_back_i         store C to addr_r_i once the answer arrives
//   addr_a_i/b_i/r_i     operand A, operand B and result addresses
//   mem_rd_req_o         level read request, held until mem_ack_i
//   mem_wr_req_o         level write request, held until mem_ack_i
//   mem_addr_o           address of the current request, 0 otherwise
//   mem_ack_i            pulse, memory request complete
//   do_clear_a_o         pulse, clear accumulator A
//   do_mem_to_c_o        pulse, load memory data into C
//   do_move_c_to_a_o     pulse, move C into A
//   do_move_c_to_b_o     pulse, move C into B
//   order_*_o            one order pulse per instruction
//   ctrl_abs_o           captured abs flag, only during the C->A/B moves
//   ac_answer_i          pulse, order complete
//   busy_o               sequencer not in IDLE
//   done_o               normal completion pulse
//   overflow_o           watchdog abort pulse (with do_clear_a_o)
//   illegal_o            illegal opcode rejected
//
// Every output is decoded from registered state only (Moore machine).
//-----------------------------------------------------------------------------
module arith_order_seq #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 80
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic [2:0]        opcode_i,
    input  logic              abs_i,
    input  logic              write_back_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [ADDR_W-1:0] addr_r_i,
    output logic              mem_rd_req_o,
    output logic              mem_wr_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    output logic              do_clear_a_o,
    output logic              do_mem_to_c_o,
    output logic              do_move_c_to_a_o,
    output logic              do_move_c_to_b_o,
    output logic              order_add_o,
    output logic              order_sub_o,
    output logic              order_mul_o,
    output logic              order_div_o,
    output logic              order_and_o,
    output logic              ctrl_abs_o,
    input  logic              ac_answer_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic              illegal_o
);

    // Counter must hold 0 .. TIMEOUT-1
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_RD_A,
        S_LD_A,
        S_MV_A,
        S_RD_B,
        S_LD_B,
        S_MV_B,
        S_ORDER,
        S_WAIT,
        S_WR,
        S_DONE,
        S_ABORT
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [2:0]        r_opcode;
    logic              r_abs;
    logic              r_write_back;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [ADDR_W-1:0] r_addr_r;
    // An illegal opcode reuses the DONE slot; this flag turns done_o into
    // illegal_o for that single cycle.
    logic              r_illegal;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic              w_legal;

    assign w_accept = (r_state == S_IDLE) && start_i;
    assign w_legal  = (opcode_i <= OP_AND);

    //-------------------------------------------------------------------------
    // State register
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    //-------------------------------------------------------------------------
    // Instruction capture. Only a legal start in IDLE loads the fields, so a
    // start during a running sequence or an illegal opcode leaves them alone.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_opcode     <= '0;
            r_abs        <= 1'b0;
            r_write_back <= 1'b0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
            r_addr_r     <= '0;
            r_illegal    <= 1'b0;
        end else if (w_accept) begin
            r_illegal <= !w_legal;
            if (w_legal) begin
                r_opcode     <= opcode_i;
                r_abs        <= abs_i;
                r_write_back <= write_back_i;
                r_addr_a     <= addr_a_i;
                r_addr_b     <= addr_b_i;
                r_addr_r     <= addr_r_i;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Watchdog counter: zeroed while the order is issued so the first WAIT
    // cycle sees 0, then counts every WAIT cycle.
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (r_state == S_ORDER) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    //-------------------------------------------------------------------------
    // Next state and Moore output decode
    //-------------------------------------------------------------------------
    always_comb begin
        w_next           = r_state;
        mem_rd_req_o     = 1'b0;
        mem_wr_req_o     = 1'b0;
        mem_addr_o       = '0;
        do_clear_a_o     = 1'b0;
        do_mem_to_c_o    = 1'b0;
        do_move_c_to_a_o = 1'b0;
        do_move_c_to_b_o = 1'b0;
        order_add_o      = 1'b0;
        order_sub_o      = 1'b0;
        order_mul_o      = 1'b0;
        order_div_o      = 1'b0;
        order_and_o      = 1'b0;
        ctrl_abs_o       = 1'b0;
        done_o           = 1'b0;
        overflow_o       = 1'b0;
        illegal_o        = 1'b0;
        busy_o           = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = w_legal ? S_CLR : S_DONE;
                end
            end

            S_CLR: begin
                do_clear_a_o = 1'b1;
                w_next       = S_RD_A;
            end

            S_RD_A: begin
                mem_rd_req_o = 1'b1;
                mem_addr_o   = r_addr_a;
                if (mem_ack_i) begin
                    w_next = S_LD_A;
                end
            end

            S_LD_A: begin
                do_mem_to_c_o = 1'b1;
                w_next        = S_MV_A;
            end

            S_MV_A: begin
                do_move_c_to_a_o = 1'b1;
                ctrl_abs_o       = r_abs;
                w_next           = S_RD_B;
            end

            S_RD_B: begin
                mem_rd_req_o = 1'b1;
                mem_addr_o   = r_addr_b;
                if (mem_ack_i) begin
                    w_next = S_LD_B;
                end
            end

            S_LD_B: begin
                do_mem_to_c_o = 1'b1;
                w_next        = S_MV_B;
            end

            S_MV_B: begin
                do_move_c_to_b_o = 1'b1;
                ctrl_abs_o       = r_abs;
                w_next           = S_ORDER;
            end

            S_ORDER: begin
                case (r_opcode)
                    OP_ADD:  order_add_o = 1'b1;
                    OP_SUB:  order_sub_o = 1'b1;
                    OP_MUL:  order_mul_o = 1'b1;
                    OP_DIV:  order_div_o = 1'b1;
                    OP_AND:  order_and_o = 1'b1;
                    default: ;
                endcase
                w_next = S_WAIT;
            end

            S_WAIT: begin
                // An answer in the final watchdog cycle still completes
                // normally, so the answer test comes first.
                if (ac_answer_i) begin
                    w_next = r_write_back ? S_WR : S_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = S_ABORT;
                end
            end

            S_WR: begin
                mem_wr_req_o = 1'b1;
                mem_addr_o   = r_addr_r;
                if (mem_ack_i) begin
                    w_next = S_DONE;
                end
            end

            S_DONE: begin
                done_o    = !r_illegal;
                illegal_o = r_illegal;
                w_next    = S_IDLE;
            end

            S_ABORT: begin
                // Abandoned order: discard the partial result in A.
                do_clear_a_o = 1'b1;
                overflow_o   = 1'b1;
                w_next       = S_IDLE;
            end

            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_arith_order_seq.sv
//-----------------------------------------------------------------------------
// Testbench for arith_order_seq. Each scenario pushes the expected active
// output cycles (cycle number relative to the start edge, output set, address)
// into a scoreboard queue and pops them as the DUT shows activity.
// Cycle 1 is the cycle right after the edge that samples start_i.
//-----------------------------------------------------------------------------
module tb_arith_order_seq;

    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 80;

    // Output set encoding, one bit per non-busy output
    localparam logic [14:0] RD   = 15'h4000;
    localparam logic [14:0] WR   = 15'h2000;
    localparam logic [14:0] CLR  = 15'h1000;
    localparam logic [14:0] M2C  = 15'h0800;
    localparam logic [14:0] C2A  = 15'h0400;
    localparam logic [14:0] C2B  = 15'h0200;
    localparam logic [14:0] ADD  = 15'h0100;
    localparam logic [14:0] SUB  = 15'h0080;
    localparam logic [14:0] MUL  = 15'h0040;
    localparam logic [14:0] DIV  = 15'h0020;
    localparam logic [14:0] AND  = 15'h0010;
    localparam logic [14:0] ABS  = 15'h0008;
    localparam logic [14:0] DONE = 15'h0004;
    localparam logic [14:0] OVF  = 15'h0002;
    localparam logic [14:0] ILL  = 15'h0001;

    logic              clk;
    logic              resetn;
    logic              start_i;
    logic [2:0]        opcode_i;
    logic              abs_i;
    logic              write_back_i;
    logic [ADDR_W-1:0] addr_a_i;
    logic [ADDR_W-1:0] addr_b_i;
    logic [ADDR_W-1:0] addr_r_i;
    logic              mem_rd_req_o;
    logic              mem_wr_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic              do_clear_a_o;
    logic              do_mem_to_c_o;
    logic              do_move_c_to_a_o;
    logic              do_move_c_to_b_o;
    logic              order_add_o;
    logic              order_sub_o;
    logic              order_mul_o;
    logic              order_div_o;
    logic              order_and_o;
    logic              ctrl_abs_o;
    logic              ac_answer_i;
    logic              busy_o;
    logic              done_o;
    logic              overflow_o;
    logic              illegal_o;

    typedef struct {
        int          cyc;
        logic [14:0] v;
        logic [11:0] a;
    } ev_t;

    ev_t sb[$];
    int  errors   = 0;
    int  checks   = 0;
    int  mem_wait = 0;

    arith_order_seq #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .start_i          (start_i),
        .opcode_i         (opcode_i),
        .abs_i            (abs_i),
        .write_back_i     (write_back_i),
        .addr_a_i         (addr_a_i),
        .addr_b_i         (addr_b_i),
        .addr_r_i         (addr_r_i),
        .mem_rd_req_o     (mem_rd_req_o),
        .mem_wr_req_o     (mem_wr_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ack_i        (mem_ack_i),
        .do_clear_a_o     (do_clear_a_o),
        .do_mem_to_c_o    (do_mem_to_c_o),
        .do_move_c_to_a_o (do_move_c_to_a_o),
        .do_move_c_to_b_o (do_move_c_to_b_o),
        .order_add_o      (order_add_o),
        .order_sub_o      (order_sub_o),
        .order_mul_o      (order_mul_o),
        .order_div_o      (order_div_o),
        .order_and_o      (order_and_o),
        .ctrl_abs_o       (ctrl_abs_o),
        .ac_answer_i      (ac_answer_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .overflow_o       (overflow_o),
        .illegal_o        (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after mem_wait extra request cycles
    initial begin
        int cnt;
        cnt       = 0;
        mem_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_rd_req_o === 1'b1 || mem_wr_req_o === 1'b1) begin
                cnt++;
                if (cnt > mem_wait) begin
                    mem_ack_i = 1'b1;
                    cnt       = 0;
                end else begin
                    mem_ack_i = 1'b0;
                end
            end else begin
                mem_ack_i = 1'b0;
                cnt       = 0;
            end
        end
    end

    function automatic logic [14:0] outv();
        return {mem_rd_req_o, mem_wr_req_o, do_clear_a_o, do_mem_to_c_o,
                do_move_c_to_a_o, do_move_c_to_b_o, order_add_o, order_sub_o,
                order_mul_o, order_div_o, order_and_o, ctrl_abs_o,
                done_o, overflow_o, illegal_o};
    endfunction

    task automatic push_ev(input int c, input logic [14:0] v, input logic [11:0] a);
        ev_t e;
        e.cyc = c;
        e.v   = v;
        e.a   = a;
        sb.push_back(e);
    endtask

    // Expected activity from CLR up to the order pulse; w = memory wait cycles
    task automatic push_prefix(input int w, input logic [11:0] aa, input logic [11:0] ab,
                               input logic abs_f, input logic [14:0] ord, output int oc);
        int          c;
        logic [14:0] absb;
        absb = abs_f ? ABS : 15'h0;
        c = 1;
        push_ev(c, CLR, 12'h0); c++;
        for (int i = 0; i <= w; i++) begin push_ev(c, RD, aa); c++; end
        push_ev(c, M2C, 12'h0); c++;
        push_ev(c, C2A | absb, 12'h0); c++;
        for (int i = 0; i <= w; i++) begin push_ev(c, RD, ab); c++; end
        push_ev(c, M2C, 12'h0); c++;
        push_ev(c, C2B | absb, 12'h0); c++;
        push_ev(c, ord, 12'h0);
        oc = c;
    endtask

    // Drives start for one cycle; returns at the cycle-1 negedge
    task automatic issue(input logic [2:0] op, input logic ab, input logic wb,
                         input logic [11:0] aa, input logic [11:0] bb, input logic [11:0] rr);
        @(negedge clk);
        start_i = 1'b1; opcode_i = op; abs_i = ab; write_back_i = wb;
        addr_a_i = aa; addr_b_i = bb; addr_r_i = rr;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start_i = 1'b0; opcode_i = 3'd0; abs_i = 1'b0;
        write_back_i = 1'b0; addr_a_i = '0; addr_b_i = '0; addr_r_i = '0;
        ac_answer_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outv() !== 15'h0 || busy_o !== 1'b0 || mem_addr_o !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs: outs=%h busy=%b addr=%h, required 0/0/0", outv(), busy_o, mem_addr_o);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (outv() !== 15'h0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: outs=%h busy=%b, required 0/0", outv(), busy_o);
        end
    endtask

    task automatic test_add_wb();
        int oc; logic [14:0] v; ev_t e;
        mem_wait = 0;
        push_prefix(0, 12'h123, 12'h456, 1'b0, ADD, oc);
        push_ev(oc + 3, WR, 12'h789);
        push_ev(oc + 4, DONE, 12'h0);
        issue(3'd0, 1'b0, 1'b1, 12'h123, 12'h456, 12'h789);
        for (int rel = 1; rel <= 16; rel++) begin
            ac_answer_i = (rel == 10);
            v = outv();
            if (v !== 15'h0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL add_wb_extra: cycle %0d outs=%h addr=%h, required no activity", rel, v, mem_addr_o);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != rel || e.v !== v || e.a !== mem_addr_o) begin
                        errors++;
                        $display("FAIL add_wb_seq: cycle %0d outs=%h addr=%h, required cycle %0d outs=%h addr=%h",
                                 rel, v, mem_addr_o, e.cyc, e.v, e.a);
                    end
                end
            end
            if (rel == 12 || rel == 13) begin
                checks++;
                if (busy_o !== (rel == 12)) begin
                    errors++;
                    $display("FAIL add_wb_busy: cycle %0d busy=%b, required %b", rel, busy_o, rel == 12);
                end
            end
            @(negedge clk);
        end
        ac_answer_i = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL add_wb_missing: %0d events outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_div_timeout();
        int oc; logic [14:0] v; ev_t e;
        mem_wait = 0;
        push_prefix(0, 12'h011, 12'h022, 1'b0, DIV, oc);
        push_ev(oc + 1 + TIMEOUT, CLR | OVF, 12'h0);
        issue(3'd3, 1'b0, 1'b1, 12'h011, 12'h022, 12'h033);
        for (int rel = 1; rel <= oc + TIMEOUT + 6; rel++) begin
            v = outv();
            if (v !== 15'h0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL div_to_extra: cycle %0d outs=%h addr=%h, required no activity", rel, v, mem_addr_o);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != rel || e.v !== v || e.a !== mem_addr_o) begin
                        errors++;
                        $display("FAIL div_to_seq: cycle %0d outs=%h addr=%h, required cycle %0d outs=%h addr=%h",
                                 rel, v, mem_addr_o, e.cyc, e.v, e.a);
                    end
                end
            end
            if (rel == oc + 1 + TIMEOUT || rel == oc + 2 + TIMEOUT) begin
                checks++;
                if (busy_o !== (rel == oc + 1 + TIMEOUT)) begin
                    errors++;
                    $display("FAIL div_to_busy: cycle %0d busy=%b, required %b", rel, busy_o, rel == oc + 1 + TIMEOUT);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL div_to_missing: %0d events outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_illegal();
        logic [14:0] v; ev_t e;
        mem_wait = 0;
        push_ev(1, ILL, 12'h0);
        issue(3'd6, 1'b0, 1'b1, 12'h0AA, 12'h0BB, 12'h0CC);
        for (int rel = 1; rel <= 6; rel++) begin
            v = outv();
            if (v !== 15'h0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL illegal_extra: cycle %0d outs=%h addr=%h, required no activity", rel, v, mem_addr_o);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != rel || e.v !== v || e.a !== mem_addr_o) begin
                        errors++;
                        $display("FAIL illegal_seq: cycle %0d outs=%h addr=%h, required cycle %0d outs=%h addr=%h",
                                 rel, v, mem_addr_o, e.cyc, e.v, e.a);
                    end
                end
            end
            if (rel <= 2) begin
                checks++;
                if (busy_o !== (rel == 1)) begin
                    errors++;
                    $display("FAIL illegal_busy: cycle %0d busy=%b, required %b", rel, busy_o, rel == 1);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL illegal_missing: %0d events outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_mul_abs_wait();
        int oc; logic [14:0] v; ev_t e;
        mem_wait = 3;
        push_prefix(3, 12'h301, 12'h302, 1'b1, MUL, oc);
        for (int i = 0; i < 4; i++) push_ev(oc + 4 + i, WR, 12'h303);
        push_ev(oc + 8, DONE, 12'h0);
        issue(3'd2, 1'b1, 1'b1, 12'h301, 12'h302, 12'h303);
        for (int rel = 1; rel <= oc + 12; rel++) begin
            // stray answer during RD_A must be ignored
            ac_answer_i = (rel == 5) || (rel == oc + 3);
            v = outv();
            if (v !== 15'h0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL mul_abs_extra: cycle %0d outs=%h addr=%h, required no activity", rel, v, mem_addr_o);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != rel || e.v !== v || e.a !== mem_addr_o) begin
                        errors++;
                        $display("FAIL mul_abs_seq: cycle %0d outs=%h addr=%h, required cycle %0d outs=%h addr=%h",
                                 rel, v, mem_addr_o, e.cyc, e.v, e.a);
                    end
                end
            end
            @(negedge clk);
        end
        ac_answer_i = 1'b0;
        mem_wait = 0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL mul_abs_missing: %0d events outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_start_in_wait();
        int oc; logic [14:0] v; ev_t e;
        mem_wait = 0;
        push_prefix(0, 12'h0C1, 12'h0C2, 1'b0, AND, oc);
        push_ev(oc + 5, WR, 12'h0C3);
        push_ev(oc + 6, DONE, 12'h0);
        issue(3'd4, 1'b0, 1'b1, 12'h0C1, 12'h0C2, 12'h0C3);
        for (int rel = 1; rel <= 18; rel++) begin
            if (rel == 9) begin
                start_i = 1'b1; opcode_i = 3'd2; abs_i = 1'b1; write_back_i = 1'b0;
                addr_a_i = 12'hF01; addr_b_i = 12'hF02; addr_r_i = 12'hF03;
            end else begin
                start_i = 1'b0;
            end
            ac_answer_i = (rel == 12);
            v = outv();
            if (v !== 15'h0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL start_wait_extra: cycle %0d outs=%h addr=%h, required no activity", rel, v, mem_addr_o);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != rel || e.v !== v || e.a !== mem_addr_o) begin
                        errors++;
                        $display("FAIL start_wait_seq: cycle %0d outs=%h addr=%h, required cycle %0d outs=%h addr=%h",
                                 rel, v, mem_addr_o, e.cyc, e.v, e.a);
                    end
                end
            end
            if (rel == 15) begin
                checks++;
                if (busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL start_wait_busy: cycle %0d busy=%b, required 0", rel, busy_o);
                end
            end
            @(negedge clk);
        end
        ac_answer_i = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL start_wait_missing: %0d events outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        int oc; logic [14:0] v; ev_t e;
        // Reset while in WAIT
        mem_wait = 0;
        push_prefix(0, 12'h201, 12'h202, 1'b0, ADD, oc);
        issue(3'd0, 1'b0, 1'b1, 12'h201, 12'h202, 12'h203);
        for (int rel = 1; rel <= 20; rel++) begin
            resetn      = (rel != 10);
            ac_answer_i = (rel == 12);
            v = outv();
            if (v !== 15'h0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rst_wait_extra: cycle %0d outs=%h addr=%h, required no activity", rel, v, mem_addr_o);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != rel || e.v !== v || e.a !== mem_addr_o) begin
                        errors++;
                        $display("FAIL rst_wait_seq: cycle %0d outs=%h addr=%h, required cycle %0d outs=%h addr=%h",
                                 rel, v, mem_addr_o, e.cyc, e.v, e.a);
                    end
                end
            end
            if (rel == 11) begin
                checks++;
                if (busy_o !== 1'b0 || v !== 15'h0 || mem_addr_o !== 12'h0) begin
                    errors++;
                    $display("FAIL rst_wait_outputs: busy=%b outs=%h addr=%h, required 0/0/0", busy_o, v, mem_addr_o);
                end
            end
            @(negedge clk);
        end
        resetn = 1'b1; ac_answer_i = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rst_wait_missing: %0d events outstanding, required 0", sb.size());
        end
        sb.delete();

        // Reset in the second cycle of RD_B (cycle 9 with 3 wait cycles)
        mem_wait = 3;
        push_prefix(3, 12'h211, 12'h212, 1'b0, ADD, oc);
        while (sb.size() > 9) sb.delete(sb.size() - 1);
        issue(3'd0, 1'b0, 1'b0, 12'h211, 12'h212, 12'h213);
        for (int rel = 1; rel <= 16; rel++) begin
            resetn = (rel != 9);
            v = outv();
            if (v !== 15'h0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rst_rdb_extra: cycle %0d outs=%h addr=%h, required no activity", rel, v, mem_addr_o);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != rel || e.v !== v || e.a !== mem_addr_o) begin
                        errors++;
                        $display("FAIL rst_rdb_seq: cycle %0d outs=%h addr=%h, required cycle %0d outs=%h addr=%h",
                                 rel, v, mem_addr_o, e.cyc, e.v, e.a);
                    end
                end
            end
            if (rel == 10) begin
                checks++;
                if (busy_o !== 1'b0 || v !== 15'h0 || mem_addr_o !== 12'h0) begin
                    errors++;
                    $display("FAIL rst_rdb_outputs: busy=%b outs=%h addr=%h, required 0/0/0", busy_o, v, mem_addr_o);
                end
            end
            @(negedge clk);
        end
        resetn = 1'b1;
        mem_wait = 0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rst_rdb_missing: %0d events outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_answer_at_timeout();
        int oc; logic [14:0] v; ev_t e;
        mem_wait = 0;
        push_prefix(0, 12'h401, 12'h402, 1'b0, SUB, oc);
        push_ev(oc + 1 + TIMEOUT, DONE, 12'h0);
        issue(3'd1, 1'b0, 1'b0, 12'h401, 12'h402, 12'h403);
        for (int rel = 1; rel <= oc + TIMEOUT + 6; rel++) begin
            // counter reaches TIMEOUT-1 in cycle oc+TIMEOUT
            ac_answer_i = (rel == oc + TIMEOUT);
            v = outv();
            if (v !== 15'h0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL ans_to_extra: cycle %0d outs=%h addr=%h, required no activity", rel, v, mem_addr_o);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != rel || e.v !== v || e.a !== mem_addr_o) begin
                        errors++;
                        $display("FAIL ans_to_seq: cycle %0d outs=%h addr=%h, required cycle %0d outs=%h addr=%h",
                                 rel, v, mem_addr_o, e.cyc, e.v, e.a);
                    end
                end
            end
            if (rel == oc + 2 + TIMEOUT) begin
                checks++;
                if (busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL ans_to_busy: cycle %0d busy=%b, required 0", rel, busy_o);
                end
            end
            @(negedge clk);
        end
        ac_answer_i = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL ans_to_missing: %0d events outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_add_wb();
        test_div_timeout();
        test_illegal();
        test_mul_abs_wait();
        test_start_in_wait();
        test_reset_mid();
        test_answer_at_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arith_order_seq.md
# arith_order_seq

Arithmetic order sequencer: the initiator side of the arithmetic control handshake. Takes one decoded arithmetic instruction (opcode, three memory addresses, abs flag) and drives the full sequence into the arithmetic control block: clear A, fetch both operands through register C into A and B, issue the order pulse, wait for the answer, and optionally write C back. A watchdog turns a missing answer (add/div overflow abandons the order silently) into an overflow report plus an A-clear abort.

## Interface
- ADDR_W, 12, memory address width
- TIMEOUT, 80, max cycles in WAIT before abort (must exceed longest order, ~64)
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start_i  in  1  pulse; accept instruction (IDLE only)
- opcode_i  in  3  0 add, 1 sub, 2 mul, 3 div, 4 and; 5-7 illegal
- abs_i  in  1  operands taken as absolute value
- write_back_i  in  1  store C to addr_r_i after answer
- addr_a_i, addr_b_i, addr_r_i  in  ADDR_W  operand A, operand B, result addresses
- mem_rd_req_o, mem_wr_req_o  out  1  level memory requests, held until ack
- mem_addr_o  out  ADDR_W  address for current request, 0 otherwise
- mem_ack_i  in  1  pulse; request complete
- do_clear_a_o, do_mem_to_c_o, do_move_c_to_a_o, do_move_c_to_b_o  out  1  pulses to arithmetic control
- order_add_o, order_sub_o, order_mul_o, order_div_o, order_and_o  out  1  order pulses
- ctrl_abs_o  out  1  level; captured abs flag, high only in MV_A/MV_B
- ac_answer_i  in  1  pulse; order complete
- busy_o  out  1  level; state != IDLE
- done_o, overflow_o, illegal_o  out  1  completion pulses

## Operation
- States: IDLE, CLR, RD_A, LD_A, MV_A, RD_B, LD_B, MV_B, ORDER, WAIT, WR, DONE, ABORT.
- IDLE: start_i with legal opcode -> capture all inputs, go CLR. Illegal opcode -> illegal_o pulse next cycle (in DONE-equivalent slot), no other outputs, back to IDLE; done_o not asserted. start_i outside IDLE ignored, captured fields unchanged.
- CLR: do_clear_a_o=1 one cycle -> RD_A.
- RD_A: mem_rd_req_o=1, mem_addr_o=addr_a; stay until mem_ack_i (ack may arrive in first cycle) -> LD_A.
- LD_A: do_mem_to_c_o=1 -> MV_A: do_move_c_to_a_o=1, ctrl_abs_o=abs -> RD_B.
- RD_B/LD_B/MV_B: same with addr_b and do_move_c_to_b_o -> ORDER.
- ORDER: exactly one order_*_o per opcode, one cycle -> WAIT; wait counter cleared to 0.
- WAIT: counter +1 per cycle. ac_answer_i -> WR if write_back else DONE. Counter == TIMEOUT-1 without answer -> ABORT. Answer in the timeout cycle wins.
- WR: mem_wr_req_o=1, mem_addr_o=addr_r until mem_ack_i -> DONE.
- DONE: done_o=1 -> IDLE. ABORT: do_clear_a_o=1, overflow_o=1 same cycle -> IDLE.
- mem_ack_i outside RD_A/RD_B/WR and ac_answer_i outside WAIT ignored.
- Never rd and wr request together; at most one of the pulse outputs to arithmetic control per cycle except ABORT (clear only).

## Timing
- Reset: state IDLE, all outputs 0, captured fields 0, counter 0; reset mid-operation drops any request immediately (next edge) without done/overflow pulse.
- All outputs registered-state decoded (Moore); no combinational path from inputs to outputs except none.
- Zero-wait memory (ack in first request cycle), start sampled at edge 0: CLR cycle 1, RD_A 2, LD_A 3, MV_A 4, RD_B 5, LD_B 6, MV_B 7, ORDER 8, WAIT from 9. Add answers in cycle 10 -> DONE cycle 11 (no write-back) or WR 11, DONE 12.
- Each memory wait cycle adds one cycle to its RD/WR state.
- Abort occurs TIMEOUT cycles after entering WAIT; busy_o drops the cycle after DONE/ABORT; new start accepted that same cycle.

## Test plan
- add, write_back=1, zero-wait memory, answer 2 cycles after order -> reads addr_a then addr_b, order_add_o in cycle 8, mem_wr_req_o cycle 11 with addr_r, done_o cycle 12, busy_o low cycle 13.
- div, ac_answer_i never asserted -> overflow_o and do_clear_a_o together exactly TIMEOUT cycles after WAIT entry, no write request, no done_o.
- opcode 6 -> illegal_o one pulse, no memory request, no order pulse, busy_o high 1 cycle only.
- mul with abs_i=1, 3 memory wait cycles per access -> ctrl_abs_o high only in MV_A and MV_B; mem_addr_o stable through wait cycles; order_mul_o once.
- start_i pulsed during WAIT with different opcode/addresses -> ignored; original sequence completes unchanged.
- resetn low in WAIT and again in RD_B -> all outputs 0 next cycle, IDLE, no done/overflow; subsequent sub completes normally with answer accepted in the same cycle as counter reaching TIMEOUT-1 -> done_o, no overflow_o.
